// File: rtl/freq_pkg.sv
// freq_pkg: shared definitions for the frequency-counter gate controller.
//   - state_t      : controller FSM encoding
//   - RUN_BIT      : switch_value bit that enables measurement
//   - SEL_LSB/W    : position/width of the gate-time code in switch_value
//   - GATE_MS_TBL  : gate code -> window length in milliseconds
//   - gate_ms()    : table lookup helper
package freq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_GATE    = 3'd2,
        ST_LATCH   = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    localparam int RUN_BIT  = 7;
    localparam int SEL_LSB  = 0;
    localparam int SEL_W    = 2;
    // Wide enough to hold 10000, the longest gate in ms.
    localparam int MS_CNT_W = 14;

    // Indexed by the 2-bit gate code: 00->10, 01->100, 10->1000, 11->10000 ms.
    localparam logic [3:0][MS_CNT_W-1:0] GATE_MS_TBL = {
        14'd10000, 14'd1000, 14'd100, 14'd10
    };

    function automatic logic [MS_CNT_W-1:0] gate_ms(input logic [SEL_W-1:0] sel);
        return GATE_MS_TBL[sel];
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: millisecond prescaler.
// Counts 0..MS_CYCLES-1 while enabled and wraps; tick is high on the
// last count of each wrap, so one tick marks the end of a full millisecond.
//   sys_clk : clock
//   sys_rst : synchronous active-high reset
//   clear   : restart the prescaler at 0 (takes priority over enable)
//   enable  : advance the prescaler this cycle
//   tick    : 1-cycle pulse on the final cycle of each millisecond
module ms_tick_gen #(
    parameter int MS_CYCLES = 50000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PW = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(MS_CYCLES - 1);

    logic [PW-1:0] presc;

    assign tick = enable && (presc == LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clear) begin
            presc <= '0;
        end else if (enable) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

endmodule

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: gate-time controller for a switch-driven frequency counter.
// Opens a measurement window of N ms (N from switch_value[1:0]), counts
// rising edges of the asynchronous sig_in inside it, publishes the count,
// waits one millisecond, and repeats while the run bit is set.
//   sys_clk      : clock, rising edge
//   sys_rst      : synchronous active-high reset
//   switch_value : [7] run, [1:0] gate code, [6:2] ignored
//   sig_in       : measured signal, asynchronous
//   gate         : high while the window is open
//   freq_count   : last completed edge count (saturating)
//   count_valid  : 1-cycle pulse, coincident with the new freq_count
//   gate_sel     : gate code latched for the current/last window
module freq_gate_ctrl
    import freq_pkg::*;
#(
    parameter int MS_CYCLES = 50000,
    parameter int CNT_W     = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [7:0]       switch_value,
    input  logic             sig_in,
    output logic             gate,
    output logic [CNT_W-1:0] freq_count,
    output logic             count_valid,
    output logic [1:0]       gate_sel
);

    state_t state, state_nxt;

    logic                run;
    logic [SEL_W-1:0]    sel_in;
    logic                unused_sw;

    logic [2:0]          sync_pipe;   // [0],[1] synchronizer, [2] history
    logic                sig_rise;

    logic                ms_tick;
    logic                presc_clr;
    logic                presc_en;
    logic [MS_CNT_W-1:0] ms_cnt;
    logic [MS_CNT_W-1:0] ms_last;
    logic                gate_done;

    logic [CNT_W-1:0]    edge_cnt;
    logic [CNT_W-1:0]    edge_cnt_nxt;

    assign run       = switch_value[RUN_BIT];
    assign sel_in    = switch_value[SEL_LSB +: SEL_W];
    assign unused_sw = ^switch_value[6:2];

    // ---------------------------------------------------------------
    // sig_in synchronizer and rising-edge detect
    // ---------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_pipe <= '0;
        end else begin
            sync_pipe <= {sync_pipe[1:0], sig_in};
        end
    end

    assign sig_rise = sync_pipe[1] & ~sync_pipe[2];

    // ---------------------------------------------------------------
    // Millisecond timebase. Cleared in ARM so the window starts on a
    // millisecond boundary, and in LATCH so HOLDOFF is a full ms.
    // ---------------------------------------------------------------
    assign presc_clr = (state == ST_ARM) || (state == ST_LATCH);
    assign presc_en  = (state == ST_GATE) || (state == ST_HOLDOFF);

    ms_tick_gen #(
        .MS_CYCLES (MS_CYCLES)
    ) u_ms_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (presc_clr),
        .enable  (presc_en),
        .tick    (ms_tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst || state == ST_ARM) begin
            ms_cnt <= '0;
        end else if (state == ST_GATE && ms_tick) begin
            ms_cnt <= ms_cnt + MS_CNT_W'(1);
        end
    end

    assign ms_last   = gate_ms(gate_sel) - MS_CNT_W'(1);
    assign gate_done = ms_tick && (ms_cnt == ms_last);

    // ---------------------------------------------------------------
    // Gate code latch: only ARM samples the switches, so mid-window
    // changes take effect at the next ARM.
    // ---------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            gate_sel <= '0;
        end else if (state == ST_ARM) begin
            gate_sel <= sel_in;
        end
    end

    // ---------------------------------------------------------------
    // Saturating edge counter
    // ---------------------------------------------------------------
    always_comb begin
        edge_cnt_nxt = edge_cnt;
        if (state == ST_ARM) begin
            edge_cnt_nxt = '0;
        end else if (state == ST_GATE && sig_rise && edge_cnt != '1) begin
            edge_cnt_nxt = edge_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt_nxt;
        end
    end

    // The result register is loaded on the GATE->LATCH transition from the
    // next-state counter value, so an edge seen on the final GATE cycle is
    // included and freq_count already holds the new value while
    // count_valid is high in LATCH.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            freq_count <= '0;
        end else if (state == ST_GATE && state_nxt == ST_LATCH) begin
            freq_count <= edge_cnt_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_ARM;
            end
            ST_ARM: begin
                state_nxt = ST_GATE;
            end
            ST_GATE: begin
                // Dropping run abandons the window before it can publish.
                if (!run)           state_nxt = ST_IDLE;
                else if (gate_done) state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                state_nxt = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (ms_tick) state_nxt = run ? ST_ARM : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        gate        = 1'b0;
        count_valid = 1'b0;
        case (state)
            ST_GATE:  gate        = 1'b1;
            ST_LATCH: count_valid = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
module tb_freq_gate_ctrl;

    logic        sys_clk;
    logic        sys_rst;
    logic [7:0]  switch_value;
    logic        sig_in;
    logic        gate, count_valid;
    logic [31:0] freq_count;
    logic [1:0]  gate_sel;
    logic        gate4, count_valid4;
    logic [3:0]  freq_count4;
    logic [1:0]  gate_sel4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int sig_per = 5;

    // results of the last measure() call
    bit          win_ok;
    int          win_len;
    logic [31:0] win_fc;
    logic [3:0]  win_fc4;
    logic [1:0]  win_gs, win_gs0;
    int          win_vcyc;
    logic        win_vnext;

    freq_gate_ctrl #(.MS_CYCLES(10), .CNT_W(32)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .switch_value(switch_value),
        .sig_in(sig_in), .gate(gate), .freq_count(freq_count),
        .count_valid(count_valid), .gate_sel(gate_sel)
    );

    freq_gate_ctrl #(.MS_CYCLES(10), .CNT_W(4)) u_dut4 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .switch_value(switch_value),
        .sig_in(sig_in), .gate(gate4), .freq_count(freq_count4),
        .count_valid(count_valid4), .gate_sel(gate_sel4)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Periodic sig_in: sig_per cycles per period, high for sig_per/2.
    initial begin
        int ph;
        ph = 0;
        sig_in = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (sig_per == 0) begin
                ph = 0;
                sig_in = 1'b0;
            end else begin
                ph = (ph + 1) % sig_per;
                sig_in = (ph < sig_per / 2);
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #2;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rise(input int budget);
        int n;
        n = 0;
        while (!gate && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Wait for a window, measure its length, then capture the published result.
    task automatic measure(input int chg_at, input logic [7:0] chg_val);
        int n;
        bit early;
        win_ok = 0;
        win_len = 0;
        early = 0;
        wait_rise(3000);
        if (!gate) return;
        win_gs0 = gate_sel;
        while (gate && win_len < 20000) begin
            if (win_len == chg_at) switch_value = chg_val;
            if (count_valid) early = 1;
            win_len++;
            tick();
        end
        n = 0;
        while (!count_valid && n < 50) begin
            tick();
            n++;
        end
        if (!count_valid) return;
        win_fc   = freq_count;
        win_fc4  = freq_count4;
        win_gs   = gate_sel;
        win_vcyc = cyc;
        tick();
        win_vnext = count_valid;
        win_ok = !early;
    endtask

    initial begin
        int v1, nvalid;
        sys_rst = 1'b1;
        switch_value = 8'h00;
        sig_per = 5;

        // Reset state
        repeat (5) tick();
        chk("rst_gate", gate, 0);
        chk("rst_valid", count_valid, 0);
        chk("rst_sel", gate_sel, 0);
        chk("rst_fc", freq_count, 0);
        chk("rst_fc4", freq_count4, 0);
        sys_rst = 1'b0;
        repeat (3) tick();

        // 10 ms gate, 5-cycle signal: 100 cycles, 20 edges
        switch_value = 8'h80;
        measure(-1, 8'h00);
        chk("w10_ok", win_ok, 1);
        chk("w10_len", win_len, 100);
        chk("w10_fc", win_fc, 20);
        chk("w10_fc4_sat", win_fc4, 15);
        chk("w10_sel", win_gs, 0);
        chk("w10_pulse1", win_vnext, 0);

        // Abort at gate cycle 50: gate drops next cycle, result untouched
        wait_rise(100);
        chk("ab_rise", gate, 1);
        repeat (50) tick();
        chk("ab_gate50", gate, 1);
        switch_value = 8'h00;
        tick();
        chk("ab_fall", gate, 0);
        nvalid = 0;
        repeat (200) begin
            if (count_valid) nvalid++;
            tick();
        end
        chk("ab_novalid", nvalid, 0);
        chk("ab_fc_kept", freq_count, 20);

        // 100 ms gate, quiet input: 1000 cycles, count 0, 1012-cycle period
        sig_per = 0;
        repeat (10) tick();
        switch_value = 8'h81;
        measure(-1, 8'h00);
        chk("w100a_ok", win_ok, 1);
        chk("w100a_len", win_len, 1000);
        chk("w100a_fc", win_fc, 0);
        chk("w100a_sel", win_gs, 1);
        v1 = win_vcyc;
        measure(-1, 8'h00);
        chk("w100b_ok", win_ok, 1);
        chk("w100b_len", win_len, 1000);
        chk("w100_period", win_vcyc - v1, 1012);
        switch_value = 8'h00;
        repeat (20) tick();

        // Gate code change mid-window only takes effect at the next ARM
        sig_per = 5;
        repeat (20) tick();
        switch_value = 8'h80;
        measure(30, 8'h83);
        chk("chg_ok", win_ok, 1);
        chk("chg_len", win_len, 100);
        chk("chg_sel0", win_gs0, 0);
        chk("chg_sel", win_gs, 0);
        chk("chg_fc", win_fc, 20);
        wait_rise(100);
        chk("chg_next_rise", gate, 1);
        chk("chg_next_sel", gate_sel, 3);
        repeat (1000) tick();
        chk("chg_next_long", gate, 1);
        switch_value = 8'h00;
        tick();
        chk("chg_abort", gate, 0);

        // Reset pulse mid-gate
        repeat (5) tick();
        switch_value = 8'h82;
        wait_rise(20);
        chk("rp_rise", gate, 1);
        chk("rp_sel_pre", gate_sel, 2);
        repeat (30) tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("rp_gate", gate, 0);
        chk("rp_valid", count_valid, 0);
        chk("rp_sel", gate_sel, 0);
        chk("rp_fc", freq_count, 0);
        chk("rp_fc4", freq_count4, 0);
        tick();
        chk("rp_arm_gate", gate, 0);
        tick();
        chk("rp_gate_again", gate, 1);
        chk("rp_sel_again", gate_sel, 2);
        switch_value = 8'h00;
        tick();
        chk("rp_abort", gate, 0);

        // 2-cycle signal: 50 edges, 4-bit instance saturates at 15
        sig_per = 2;
        repeat (20) tick();
        switch_value = 8'h80;
        measure(-1, 8'h00);
        chk("sat_ok", win_ok, 1);
        chk("sat_len", win_len, 100);
        chk("sat_fc", win_fc, 50);
        chk("sat_fc4", win_fc4, 4'hF);
        switch_value = 8'h00;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
